// File: rtl/gshare_bht.sv
// gshare_bht: gshare branch history table with a global history register and a post-reset/flush clear sweep.
// Ports: clk_i/rst_ni clock and sync active-low reset; flush_i restarts the clear sweep; debug_mode_i blocks table writes;
//   vpc_i fetch PC -> pred_valid_o/pred_taken_o per slot, pred_hist_o GHR snapshot; busy_o clear sweep active;
//   spec_valid_i/spec_taken_i speculative GHR shift; update_* resolved-branch training and mispredict GHR restore.
// Macro BHT_GSHARE_EN: history-XOR indexing and live GHR; undefined gives bimodal indexing with GHR held at 0.
module gshare_bht #(
  parameter int unsigned NR_ENTRIES = 1024,
  parameter int unsigned HIST_BITS  = 8,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned NR_PRED    = 2,
  parameter int unsigned PC_W       = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 debug_mode_i,
  input  logic [PC_W-1:0]      vpc_i,
  output logic [NR_PRED-1:0]   pred_valid_o,
  output logic [NR_PRED-1:0]   pred_taken_o,
  output logic [HIST_BITS-1:0] pred_hist_o,
  output logic                 busy_o,
  input  logic                 spec_valid_i,
  input  logic                 spec_taken_i,
  input  logic                 update_valid_i,
  input  logic [PC_W-1:0]      update_pc_i,
  input  logic                 update_taken_i,
  input  logic [HIST_BITS-1:0] update_hist_i,
  input  logic                 update_mispredict_i
);
  localparam int unsigned IB = $clog2(NR_ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b1, {(CTR_BITS-1){1'b0}}};
  typedef enum logic {CLEAR, IDLE} state_e;
  state_e state_q, state_d;
  logic [IB-1:0] clr_idx_q, clr_idx_d;
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  logic tbl_valid_q [NR_ENTRIES];
  logic [CTR_BITS-1:0] tbl_ctr_q [NR_ENTRIES];
  logic [HIST_BITS-1:0] hash_ghr, hash_uhist;
  logic [IB-1:0] uidx;
  logic [CTR_BITS-1:0] uctr, upd_ctr;
  logic upd_en;
  logic unused_ok;

  // History occupies the top bits of the index so short histories still spread over the table.
  function automatic logic [IB-1:0] idx(input logic [IB-1:0] p, input logic [HIST_BITS-1:0] h);
    return p ^ (IB'(h) << (IB - HIST_BITS));
  endfunction

`ifdef BHT_GSHARE_EN
  assign hash_ghr   = ghr_q;
  assign hash_uhist = update_hist_i;
  // Truncating {old, new_bit} to HIST_BITS drops the oldest bit; also covers HIST_BITS=1.
  always_comb ghr_d = flush_i ? '0 :
                      (update_valid_i && update_mispredict_i) ? HIST_BITS'({update_hist_i, update_taken_i}) :
                      spec_valid_i ? HIST_BITS'({ghr_q, spec_taken_i}) : ghr_q;
`else
  assign hash_ghr   = '0;
  assign hash_uhist = '0;
  always_comb ghr_d = '0;
`endif

  assign unused_ok = ^{vpc_i, update_pc_i, update_hist_i, spec_valid_i, spec_taken_i, update_mispredict_i};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      ghr_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ghr_q     <= ghr_d;
    end
  end

  always_comb begin
    state_d   = flush_i ? CLEAR : (state_q == CLEAR && clr_idx_q == IB'(NR_ENTRIES - 1)) ? IDLE : state_q;
    clr_idx_d = (flush_i || state_q != CLEAR) ? '0 : clr_idx_q + 1'b1;
  end

  always_comb begin
    busy_o      = state_q == CLEAR;
    pred_hist_o = ghr_q;
  end

  for (genvar g = 0; g < NR_PRED; g++) begin : g_slot
    logic [IB-1:0] pidx;
    assign pidx = idx((vpc_i[IB:1] & ~IB'(NR_PRED - 1)) | IB'(g), hash_ghr);
    assign pred_valid_o[g] = tbl_valid_q[pidx] & ~busy_o;
    assign pred_taken_o[g] = tbl_ctr_q[pidx][CTR_BITS-1];
  end

  assign uidx    = idx(update_pc_i[IB:1], hash_uhist);
  assign uctr    = tbl_ctr_q[uidx];
  assign upd_ctr = update_taken_i ? (&uctr ? uctr : uctr + CTR_BITS'(1)) : (|uctr ? uctr - CTR_BITS'(1) : uctr);
  assign upd_en  = update_valid_i & ~debug_mode_i & ~busy_o & ~flush_i & rst_ni;

  // Table needs no reset: the sweep rewrites every entry before any is reported valid.
  always_ff @(posedge clk_i) begin
    if (busy_o) begin
      tbl_valid_q[clr_idx_q] <= 1'b0;
      tbl_ctr_q[clr_idx_q]   <= CTR_INIT;
    end else if (upd_en) begin
      tbl_valid_q[uidx] <= 1'b1;
      tbl_ctr_q[uidx]   <= upd_ctr;
    end
  end
endmodule

// File: doc/gshare_bht.md
GSHARE_BHT -- requirements
Module: gshare_bht

Interface
REQ-001 SHALL have parameter NR_ENTRIES, default 1024, table depth (power of two, >= 4); INDEX_BITS = log2(NR_ENTRIES).
REQ-002 SHALL have parameter HIST_BITS, default 8, global history length, 1..INDEX_BITS.
REQ-003 SHALL have parameter CTR_BITS, default 2, saturating counter width, 2..4.
REQ-004 SHALL have parameter NR_PRED, default 2, predictions per fetch (power of two, >= 1).
REQ-005 SHALL have parameter PC_W, default 64, virtual PC width.
REQ-006 SHALL have ports clk_i in 1 clock; rst_ni in 1 reset; one clock, reset synchronous and active-low.
REQ-007 SHALL have flush_i in 1 (restart clear sweep); debug_mode_i in 1 (suppress table updates).
REQ-008 SHALL have vpc_i in PC_W (fetch PC); pred_valid_o out NR_PRED; pred_taken_o out NR_PRED; pred_hist_o out HIST_BITS (GHR snapshot used for this prediction); busy_o out 1 (clear sweep active).
REQ-009 SHALL have spec_valid_i in 1, spec_taken_i in 1: a predicted conditional branch was consumed; shift speculative GHR.
REQ-010 SHALL have update_valid_i in 1, update_pc_i in PC_W, update_taken_i in 1, update_hist_i in HIST_BITS (snapshot from prediction time), update_mispredict_i in 1.

Function
REQ-011 SHALL hold per entry {valid, ctr[CTR_BITS-1:0]}; idx(pc,h) = pc[INDEX_BITS:1] XOR {h, (INDEX_BITS-HIST_BITS) zeros}.
REQ-012 SHALL compute slot i PC as vpc_i with bits [log2(NR_PRED):1] replaced by i; prediction is combinational (zero latency) from registered state using current GHR.
REQ-013 SHALL drive pred_valid_o[i] = entry valid, pred_taken_o[i] = ctr MSB, pred_hist_o = GHR; while busy_o=1 pred_valid_o SHALL be all 0.
REQ-014 SHALL, on update_valid_i and not debug_mode_i and not busy_o, set entry idx(update_pc_i, update_hist_i) valid=1, ctr +1 if taken else -1, saturating at all-ones / zero; registered next cycle.
REQ-015 SHALL return pre-update entry value when prediction and update hit the same index in the same cycle.
REQ-016 SHALL update GHR: update_valid_i and update_mispredict_i -> GHR <= {update_hist_i[HIST_BITS-2:0], update_taken_i}; else spec_valid_i -> GHR <= {GHR[HIST_BITS-2:0], spec_taken_i}; else hold. Restore wins over simultaneous shift (shift dropped). GHR restore/shift SHALL occur regardless of debug_mode_i. (HIST_BITS=1: restore gives update_taken_i.)
REQ-017 SHALL implement FSM CLEAR/IDLE: CLEAR writes entry clr_idx to {0, 2^(CTR_BITS-1)} (invalid, weakly taken), clr_idx+1 per cycle; after index NR_ENTRIES-1 go IDLE; busy_o=1 exactly in CLEAR.
REQ-018 SHALL, on flush_i (any state, incl. mid-sweep), enter CLEAR with clr_idx=0 and GHR=0 next cycle; updates and spec shifts that cycle are dropped.
REQ-019 SHALL drop updates while busy_o=1 (no effect on table).

Reset
REQ-020 SHALL, on rst_ni=0 at clock edge, set GHR=0, clr_idx=0, state CLEAR; busy_o=1, pred_valid_o=0, pred_hist_o=0 from the first cycle after reset.
REQ-021 SHALL restart the sweep at 0 if reset is asserted mid-sweep or mid-operation; table contents before sweep completion are never reported valid.

Configuration
REQ-022 SHALL, with macro BHT_GSHARE_EN defined, use history-XOR indexing per REQ-011 and REQ-016.
REQ-023 SHALL, without BHT_GSHARE_EN, index by pc[INDEX_BITS:1] only (bimodal), hold GHR at 0, drive pred_hist_o=0, and ignore update_hist_i, spec_* and update_mispredict_i.

Verification (defaults, BHT_GSHARE_EN defined)
REQ-024 Reset 1 cycle -> busy_o=1 for exactly 1024 cycles, pred_valid_o=00; then vpc_i=0x100 -> pred_valid_o=00, pred_taken_o=11.
REQ-025 GHR=0, three updates pc=0x100 taken hist=0 -> vpc_i=0x100 gives pred_valid_o[0]=1, taken=1 (ctr 11); one not-taken -> taken=1; second not-taken -> taken=0.
REQ-026 spec shifts 1,1,0 from GHR=0 -> pred_hist_o=0x06; update pc=0x100 hist=0x06 writes entry 0x080^0x018=0x098.
REQ-027 Same cycle spec_valid_i=1 and mispredict update hist=0x0F taken=0 -> GHR=0x1E next cycle.
REQ-028 flush_i at clr_idx=500 -> sweep restarts, busy_o=1 for 1024 further cycles; update issued during sweep leaves entry invalid.
REQ-029 debug_mode_i=1 with update pc=0x100 taken -> entry unchanged; mispredict restore still updates GHR.
